// File: rtl/matmul_fx_if.sv
// Operand/result bus of the matmul_fx fixed-point matrix multiplier.
// Packing: element (0,0) sits in the MSBs, row-major.
interface matmul_fx_if #(
   parameter int unsigned S = 16,
   parameter int unsigned H = 4,
   parameter int unsigned W = 1,
   parameter int unsigned C = 2
);
   logic             start;
   logic             acc;
   logic [H*C*S-1:0] a;
   logic [C*W*S-1:0] b;
   logic [H*W*S-1:0] o;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, acc, a, b,
      input  o, busy, done, ovf
   );

   modport slave (
      input  start, acc, a, b,
      output o, busy, done, ovf
   );
endinterface

// File: rtl/matmul_fx.sv
// Sequential fixed-point matrix multiplier: O = A*B or O = O + A*B, one row per C cycles.
// Define MATMUL_FX_SAT_EN to saturate overflowing results; otherwise they wrap.
module matmul_fx #(
   parameter int unsigned S    = 16,
   parameter int unsigned FRAC = 8,
   parameter int unsigned H    = 4,
   parameter int unsigned W    = 1,
   parameter int unsigned C    = 2
) (
   input logic        clk,
   input logic        rst,
   matmul_fx_if.slave bus
);
   localparam int unsigned AW = 2 * S + $clog2(C) + 1;
   localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
   localparam int unsigned KW = (C > 1) ? $clog2(C) : 1;
   localparam logic [AW-1:0] Half = AW'(1) << (FRAC - 1);

   typedef enum logic [1:0] {StIdle, StMac, StFin} state_e;

   state_e state_q, state_d;

   logic [H*C*S-1:0] a_q;
   logic [C*W*S-1:0] b_q;
   logic             acc_mode_q;
   logic [RW-1:0]    row_q;
   logic [KW-1:0]    col_q;
   logic             ovf_q;
   logic             done_q;

   logic signed [AW-1:0] lane_acc_q [W];
   logic signed [S-1:0]  o_q        [H][W];

   logic busy, done_d, accept, mac_en, last_k, last_row;

   logic signed [S-1:0]    a_el;
   logic signed [S-1:0]    b_el    [W];
   logic signed [2*S-1:0]  prod    [W];
   logic signed [AW-1:0]   preload [W];
   logic signed [AW-1:0]   base    [W];
   logic signed [AW-1:0]   sum     [W];
   logic signed [AW-1:0]   rnd     [W];
   logic signed [AW-1:0]   shr     [W];
   logic signed [S-1:0]    res     [W];
   logic [W-1:0]           lane_ovf;

   assign last_k   = (col_q == KW'(C - 1));
   assign last_row = (row_q == RW'(H - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StMac;
         StMac:   if (last_k && last_row) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output / control decode
   always_comb begin
      busy   = 1'b0;
      done_d = 1'b0;
      accept = 1'b0;
      mac_en = 1'b0;
      unique case (state_q)
         StIdle:  accept = bus.start;
         StMac: begin
            busy   = 1'b1;
            mac_en = 1'b1;
         end
         StFin: begin
            busy   = 1'b1;
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Operand selection for the current (row, k) step
   always_comb begin
      a_el = '0;
      for (int i = 0; i < H; i++) begin
         for (int k = 0; k < C; k++) begin
            if (row_q == RW'(i) && col_q == KW'(k)) begin
               a_el = a_q[(H*C - (i*C + k))*S - 1 -: S];
            end
         end
      end
      for (int j = 0; j < W; j++) begin
         b_el[j] = '0;
         for (int k = 0; k < C; k++) begin
            if (col_q == KW'(k)) begin
               b_el[j] = b_q[(C*W - (k*W + j))*S - 1 -: S];
            end
         end
      end
   end

   // MAC lanes with round-half-up, rescale and range reduction
   always_comb begin
      for (int j = 0; j < W; j++) begin
         prod[j]    = a_el * b_el[j];
         preload[j] = acc_mode_q ?
                      ({{(AW-S){o_q[row_q][j][S-1]}}, o_q[row_q][j]} << FRAC) : '0;
         base[j]    = (col_q == '0) ? preload[j] : lane_acc_q[j];
         sum[j]     = base[j] + {{(AW-2*S){prod[j][2*S-1]}}, prod[j]};
         rnd[j]     = sum[j] + Half;
         shr[j]     = rnd[j] >>> FRAC;
         // In range only if every bit from S-1 upward matches the sign
         lane_ovf[j] = ~((&shr[j][AW-1:S-1]) | ~(|shr[j][AW-1:S-1]));
`ifdef MATMUL_FX_SAT_EN
         if (lane_ovf[j]) begin
            res[j] = shr[j][AW-1] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
         end else begin
            res[j] = shr[j][S-1:0];
         end
`else
         res[j] = shr[j][S-1:0];
`endif
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         acc_mode_q <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
         for (int j = 0; j < W; j++) begin
            lane_acc_q[j] <= '0;
         end
         for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
               o_q[i][j] <= '0;
            end
         end
      end else begin
         done_q <= done_d;
         if (accept) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            acc_mode_q <= bus.acc;
            ovf_q      <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
         end else if (mac_en) begin
            for (int j = 0; j < W; j++) begin
               if (last_k) begin
                  o_q[row_q][j] <= res[j];
               end
               lane_acc_q[j] <= last_k ? '0 : sum[j];
            end
            if (last_k) begin
               col_q <= '0;
               row_q <= last_row ? '0 : row_q + RW'(1);
               if (|lane_ovf) begin
                  ovf_q <= 1'b1;
               end
            end else begin
               col_q <= col_q + KW'(1);
            end
         end
      end
   end

   for (genvar gi = 0; gi < H; gi++) begin : g_row
      for (genvar gj = 0; gj < W; gj++) begin : g_col
         assign bus.o[(H*W - (gi*W + gj))*S - 1 -: S] = o_q[gi][gj];
      end
   end

   assign bus.busy = busy;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_matmul_fx.sv
// Self-checking bench for matmul_fx: directed scenarios plus random operations
// checked against an integer-arithmetic reference model.
module tb_matmul_fx;
   localparam int S      = 16;
   localparam int FRAC   = 8;
   localparam int H      = 4;
   localparam int W      = 1;
   localparam int C      = 2;
   localparam int LAT    = H * C + 1;
   localparam int BUDGET = 40;
   localparam longint MAXV = (64'sd1 <<< (S - 1)) - 1;
   localparam longint MINV = -(64'sd1 <<< (S - 1));

   logic clk;
   logic rst;

   matmul_fx_if #(.S(S), .H(H), .W(W), .C(C)) bus ();

   matmul_fx #(.S(S), .FRAC(FRAC), .H(H), .W(W), .C(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total;
   int bad;

   logic [S-1:0]     exp_o [H][W];
   logic             exp_ovf;
   logic [H*W*S-1:0] exp_bus;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic signed [S-1:0] el_a(input logic [H*C*S-1:0] v, input int i,
                                                input int k);
      logic [H*C*S-1:0] t;
      t = v >> ((H*C - 1 - (i*C + k)) * S);
      return t[S-1:0];
   endfunction

   function automatic logic signed [S-1:0] el_b(input logic [C*W*S-1:0] v, input int k,
                                                input int j);
      logic [C*W*S-1:0] t;
      t = v >> ((C*W - 1 - (k*W + j)) * S);
      return t[S-1:0];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) exp_o[i][j] = '0;
      exp_ovf = 1'b0;
   endtask

   // Real-number semantics: exact sum of products, round half up, then fit S bits
   task automatic model(input logic [H*C*S-1:0] av, input logic [C*W*S-1:0] bv,
                        input bit accm);
      longint s;
      longint r;
      logic signed [S-1:0] prev;
      exp_ovf = 1'b0;
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < W; j++) begin
            prev = exp_o[i][j];
            s = accm ? (longint'(prev) * (64'sd1 <<< FRAC)) : 64'sd0;
            for (int k = 0; k < C; k++) begin
               s += longint'(el_a(av, i, k)) * longint'(el_b(bv, k, j));
            end
            r = (s + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
            if (r > MAXV || r < MINV) begin
               exp_ovf = 1'b1;
`ifdef MATMUL_FX_SAT_EN
               r = (r > MAXV) ? MAXV : MINV;
`endif
            end
            exp_o[i][j] = r[S-1:0];
         end
      end
      exp_bus = '0;
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < W; j++) begin
            exp_bus = (exp_bus << S) | {{(H*W*S-S){1'b0}}, exp_o[i][j]};
         end
      end
   endtask

   function automatic logic [15:0] rand_el();
      logic [31:0] r;
      r = $urandom;
      if (r[1:0] == 2'b00) return r[31:16];
      return {{4{r[15]}}, r[15:4]};
   endfunction

   function automatic logic [H*C*S-1:0] rand_a();
      logic [H*C*S-1:0] v;
      for (int n = 0; n < H*C; n++) v[n*S +: S] = rand_el();
      return v;
   endfunction

   function automatic logic [C*W*S-1:0] rand_b();
      logic [C*W*S-1:0] v;
      for (int n = 0; n < C*W; n++) v[n*S +: S] = rand_el();
      return v;
   endfunction

   // Drives a start at the current negedge and returns how many cycles until done (-1: none).
   // If poke > 0, start is re-asserted with altered operands after edge 'poke' for one cycle.
   task automatic launch(input logic [H*C*S-1:0] av, input logic [C*W*S-1:0] bv,
                         input bit accm, input int poke, output int lat);
      bus.a     = av;
      bus.b     = bv;
      bus.acc   = accm;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = -1;
      for (int n = 1; n <= BUDGET; n++) begin
         @(negedge clk);
         if (n == poke + 1) bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
         if (n == poke) begin
            bus.start = 1'b1;
            bus.a     = ~av;
            bus.b     = ~bv;
            bus.acc   = ~accm;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.acc   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      total++; if (bus.o !== '0) begin bad++; $display("FAIL reset_o: got %h want 0", bus.o); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_basic();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      logic [H*W*S-1:0] want;
      int lat;
      av   = {H{16'h0100, 16'h0200}};
      bv   = {16'h0100, 16'h0100};
      want = {H*W{16'h0300}};
      model(av, bv, 1'b0);
      launch(av, bv, 1'b0, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== want) begin bad++; $display("FAIL basic_o: got %h want %h", bus.o, want); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf: got %b want 0", bus.ovf); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", bus.busy); end
      @(negedge clk);
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
   endtask

   task automatic test_accumulate();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      logic [H*W*S-1:0] want;
      int lat;
      av   = {H{16'h0100, 16'h0200}};
      bv   = {16'h0100, 16'h0100};
      want = {H*W{16'h0600}};
      model(av, bv, 1'b1);
      launch(av, bv, 1'b1, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL acc_latency: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== want) begin bad++; $display("FAIL acc_o: got %h want %h", bus.o, want); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL acc_ovf: got %b want 0", bus.ovf); end
   endtask

   task automatic test_overflow();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      logic [H*W*S-1:0] want;
      int lat;
      av = {H*C{16'h7F00}};
      bv = {C*W{16'h7F00}};
`ifdef MATMUL_FX_SAT_EN
      want = {H*W{16'h7FFF}};
`else
      want = {H*W{16'h0200}};
`endif
      model(av, bv, 1'b0);
      launch(av, bv, 1'b0, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL ovf_latency: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== want) begin bad++; $display("FAIL ovf_o: got %h want %h", bus.o, want); end
      total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
      @(negedge clk);
      total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
   endtask

   task automatic test_rounding();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      logic [H*W*S-1:0] want;
      int lat;
      av   = {16'h0001, 16'h0000, 16'hFF80, 16'h0000, 32'h0, 32'h0};
      bv   = {16'h0080, 16'h0000};
      want = {16'h0001, 16'hFFC0, 16'h0000, 16'h0000};
      model(av, bv, 1'b0);
      launch(av, bv, 1'b0, -10, lat);
      total++; if (bus.o !== want) begin bad++; $display("FAIL round_o: got %h want %h", bus.o, want); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL round_ovf_cleared: got %b want 0", bus.ovf); end
   endtask

   task automatic test_control();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      logic [H*W*S-1:0] want;
      int lat;
      int seen;
      av   = {H{16'h0100, 16'h0200}};
      bv   = {16'h0100, 16'h0100};
      want = {H*W{16'h0300}};
      model(av, bv, 1'b0);
      launch(av, bv, 1'b0, 3, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL ctrl_latency: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== want) begin bad++; $display("FAIL ctrl_o: got %h want %h", bus.o, want); end
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL ctrl_extra_done: got %0d want 0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      int lat;
      av = rand_a();
      bv = rand_b();
      model(av, bv, 1'b0);
      launch(av, bv, 1'b0, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_lat1: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== exp_bus) begin bad++; $display("FAIL b2b_o1: got %h want %h", bus.o, exp_bus); end
      av = rand_a();
      bv = rand_b();
      model(av, bv, 1'b1);
      launch(av, bv, 1'b1, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== exp_bus) begin bad++; $display("FAIL b2b_o2: got %h want %h", bus.o, exp_bus); end
      total++; if (bus.ovf !== exp_ovf) begin bad++; $display("FAIL b2b_ovf2: got %b want %b", bus.ovf, exp_ovf); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      int lat;
      int seen;
      av = {H{16'h0100, 16'h0200}};
      bv = {16'h0100, 16'h0100};
      bus.a     = av;
      bus.b     = bv;
      bus.acc   = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
      total++; if (bus.o !== '0) begin bad++; $display("FAIL rmid_o: got %h want 0", bus.o); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", bus.done); end
      rst = 1'b0;
      model_clear();
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rmid_stray_done: got %0d want 0", seen); end
      model(av, bv, 1'b1);
      launch(av, bv, 1'b1, -10, lat);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rmid_latency: got %0d want %0d", lat, LAT); end
      total++; if (bus.o !== exp_bus) begin bad++; $display("FAIL rmid_o_after: got %h want %h", bus.o, exp_bus); end
   endtask

   task automatic test_random();
      logic [H*C*S-1:0] av;
      logic [C*W*S-1:0] bv;
      bit accm;
      int lat;
      for (int n = 0; n < 24; n++) begin
         av   = rand_a();
         bv   = rand_b();
         accm = ($urandom_range(0, 1) == 1);
         model(av, bv, accm);
         launch(av, bv, accm, -10, lat);
         total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); end
         total++; if (bus.o !== exp_bus) begin bad++; $display("FAIL rand_o[%0d]: got %h want %h", n, bus.o, exp_bus); end
         total++; if (bus.ovf !== exp_ovf) begin bad++; $display("FAIL rand_ovf[%0d]: got %b want %b", n, bus.ovf, exp_ovf); end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.start = 1'b0;
      bus.acc   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_accumulate();
      test_overflow();
      test_rounding();
      test_control();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_fx.md
# matmul_fx

Sequential, parametrised fixed-point matrix multiplier computing O = A·B, or O = O + A·B in accumulate mode, for H×C by C×W operands. It is the successor of the combinational-width `matmul` block: one row of O is produced every C cycles using W parallel multiply-accumulate lanes. Results are rounded and saturated, and a sticky overflow flag is provided. It sits between the weight/activation registers and the next layer stage of the inference datapath.

## Interface
- `S`, 16: element width in bits, signed two's complement.
- `FRAC`, 8: fractional bits per element (Q(S-FRAC).FRAC); 1 ≤ FRAC < S.
- `H`, 4: rows of A and O.
- `W`, 1: columns of B and O; equals the number of parallel MAC lanes.
- `C`, 2: common dimension.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin an operation; sampled only in IDLE.
- `acc` input 1: sampled with `start`; 1 means accumulate onto the current `o`.
- `a` input H*C*S: matrix A, row-major, element (0,0) in the MSBs; A(i,k) occupies bits [(H*C-(i*C+k))*S-1 -: S].
- `b` input C*W*S: matrix B, same packing rule with width W.
- `o` output H*W*S: result matrix, same packing rule; registered.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `o` holds the new result.
- `ovf` output 1: sticky; set if any output element overflowed S bits during the last operation.

## Operation
- States: IDLE, MAC, FIN.
- IDLE, `start`=1:
  - Latch `a`, `b` and `acc` into internal registers; later changes to the inputs have no effect.
  - Clear `ovf`; set row i=0 and k=0; go to MAC.
- MAC, one cycle per (i,k):
  - Each lane j adds A(i,k)·B(k,j) to its accumulator.
  - Accumulator width is 2S+clog2(C)+1, so intermediate sums never overflow.
  - At k=0 the accumulator is preloaded with 0, or with o(i,j) sign-extended and shifted left by FRAC when `acc`=1.
  - At k=C-1: accumulator + 2^(FRAC-1) (round half up), arithmetic shift right by FRAC, reduce to S bits, write into o(i,j), then i++, k=0. Otherwise k++.
  - After the final write at i=H-1, go to FIN.
- FIN: pulse `done`, then return to IDLE.
- Reduction to S bits, for a value outside [-2^(S-1), 2^(S-1)-1]:
  - With saturation: clamp to 0x7FF…F or 0x800…0.
  - Without saturation: keep the low S bits.
  - In both cases set `ovf`.
- `o` rows are written progressively. `o` is architecturally valid only from `done` until the next accepted `start`.
- `start` while `busy`=1 is ignored and is not queued.
- `rst` at any time, including mid-operation, forces on the next edge:
  - state to IDLE;
  - `o`=0, `busy`=0, `done`=0, `ovf`=0;
  - internal counters and accumulators to 0.

## Timing
- Edge 0: `start` is sampled in IDLE.
- `busy`=1 from edge 0 through edge H*C+1.
- Row i is written at edge (i+1)·C.
- `done`=1 for exactly one cycle after edge H*C+1; `busy` drops at the same edge.
- Total latency is H*C+1 cycles from `start` to `done`. Default parameters give 9 cycles.
- A new `start` may be asserted in the cycle `done` is high; it is accepted at the following edge. Back-to-back throughput is H*C+2 cycles.
- Reset values of every output are 0.

## Configuration
- `MATMUL_FX_SAT_EN` defined: overflowing results saturate to the S-bit signed maximum or minimum.
- `MATMUL_FX_SAT_EN` undefined: overflowing results wrap (low S bits kept).
- `ovf` behaves identically in both builds.

## Test plan
All scenarios use default parameters (S=16, FRAC=8, H=4, W=1, C=2).
- Basic: every A row = [0x0100, 0x0200], B = [0x0100, 0x0100], `acc`=0 → `o` = 0x0300 in all 4 elements; `done` pulses 9 cycles after `start`; `ovf`=0.
- Accumulate: repeat the basic scenario with `acc`=1 → all elements 0x0600.
- Overflow: all A and B elements = 0x7F00 (127.0) → with `MATMUL_FX_SAT_EN`, all elements 0x7FFF; without it, all 0x0200; `ovf`=1 in both builds.
- Rounding and sign:
  - A row 0 = [0x0001, 0x0000], B = [0x0080, 0x0000] → o(0) = 0x0001 (half rounded up).
  - A row 1 = [0xFF80, 0x0000], same B → o(1) = 0xFFC0 (-0.25).
- Control:
  - `start` pulsed again at cycle 3 of an operation → ignored; a single `done` at cycle 9.
  - Inputs `a`/`b` changed mid-operation → result unaffected.
- Reset mid-operation: `rst`=1 at cycle 4 → next edge gives `busy`=0, `o`=0, no `done`; a fresh `start` then completes normally.
